// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control path: sequencer states,
// opcode patterns with their don't-care masks, immediate-format and ALU-op
// encodings, and the instruction class used by the decoder, sign-extend and
// ALU control blocks.
package legv8_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    // Instruction classes recognised by the decoder
    typedef enum logic [2:0] {
        ClsLdur,
        ClsStur,
        ClsRtype,
        ClsCbz,
        ClsB,
        ClsIllegal
    } instr_class_e;

    // Sign-extend format select
    typedef enum logic [1:0] {
        ImmD  = 2'b00,
        ImmCb = 2'b01,
        ImmB  = 2'b10
    } imm_sel_e;

    // ALU operation class handed to ALU control
    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluPassB = 2'b01,
        AluFunct = 2'b10
    } alu_op_e;

    // Opcode patterns, instruction[31:21]
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpCbz  = 11'b10110100000;
    localparam logic [10:0] OpB    = 11'b00010100000;

    // Masks: a 1 marks a bit that must match the pattern
    localparam logic [10:0] MaskFull = 11'b11111111111;
    localparam logic [10:0] MaskCbz  = 11'b11111111000;
    localparam logic [10:0] MaskB    = 11'b11111100000;

    // True when op matches pattern on every bit selected by mask
    function automatic logic op_match(logic [10:0] op, logic [10:0] pattern,
                                      logic [10:0] mask);
        return (op & mask) == (pattern & mask);
    endfunction

    // Immediate format implied by an instruction class; classes without an
    // immediate default to the D format so the select never floats
    function automatic imm_sel_e imm_sel_of(instr_class_e cls);
        imm_sel_e sel;
        case (cls)
            ClsCbz:  sel = ImmCb;
            ClsB:    sel = ImmB;
            default: sel = ImmD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/legv8_mc_ctrl_if.sv
// Bus between the multi-cycle control sequencer and the datapath: opcode and
// status in, enables/selects/strobes and counters out.
interface legv8_mc_ctrl_if #(
    parameter int unsigned INSTRET_W = 32
);
    logic                 run;
    logic [10:0]          opcode;
    logic                 zero;
    logic                 imem_ready;
    logic                 dmem_ready;

    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_src;
    logic [1:0]           imm_sel;
    logic                 alu_src;
    logic [1:0]           alu_op;
    logic                 imem_read;
    logic                 dmem_read;
    logic                 dmem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 illegal;
    logic [INSTRET_W-1:0] instret;
    logic                 busy;

    // Controller side
    modport master (
        input  run, opcode, zero, imem_ready, dmem_ready,
        output ir_write, pc_write, pc_src, imm_sel, alu_src, alu_op,
        output imem_read, dmem_read, dmem_write, reg_write, mem_to_reg,
        output illegal, instret, busy
    );

    // Datapath / memory side
    modport slave (
        output run, opcode, zero, imem_ready, dmem_ready,
        input  ir_write, pc_write, pc_src, imm_sel, alu_src, alu_op,
        input  imem_read, dmem_read, dmem_write, reg_write, mem_to_reg,
        input  illegal, instret, busy
    );

endinterface

// File: rtl/legv8_opdecode.sv
// Combinational opcode classifier. Maps instruction[31:21] onto an
// instruction class and flags anything outside the supported set. Shared with
// the ALU control block.
module legv8_opdecode
    import legv8_pkg::*;
(
    input  logic [10:0]  opcode_i,
    output instr_class_e cls_o,
    output logic         illegal_o
);

    // Priority match; the patterns are disjoint so order only affects timing
    always_comb begin
        cls_o = ClsIllegal;
        if (op_match(opcode_i, OpLdur, MaskFull)) begin
            cls_o = ClsLdur;
        end else if (op_match(opcode_i, OpStur, MaskFull)) begin
            cls_o = ClsStur;
        end else if (op_match(opcode_i, OpAdd, MaskFull) ||
                     op_match(opcode_i, OpSub, MaskFull) ||
                     op_match(opcode_i, OpAnd, MaskFull) ||
                     op_match(opcode_i, OpOrr, MaskFull)) begin
            cls_o = ClsRtype;
        end else if (op_match(opcode_i, OpCbz, MaskCbz)) begin
            cls_o = ClsCbz;
        end else if (op_match(opcode_i, OpB, MaskB)) begin
            cls_o = ClsB;
        end
        illegal_o = (cls_o == ClsIllegal);
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multi-cycle control sequencer for the LEGv8 datapath. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, handles memory wait states and
// counts retired instructions. Outputs are decoded from the state register and
// the IR opcode field (stable from DECODE onward).
//
// Build option: define LEGV8_ILLEGAL_TRAP_EN to trap undecodable opcodes into
// HALT and raise the sticky illegal flag. Without it an undecodable opcode
// retires as a 3-cycle NOP.
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input logic            clk,
    input logic            rst_n,
    legv8_mc_ctrl_if.master bus
);

    state_e               state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 illegal_q, illegal_d;

    instr_class_e         cls;
    logic                 dec_illegal;
    logic                 retire;

    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_src;
    imm_sel_e             imm_sel;
    logic                 alu_src;
    alu_op_e              alu_op;
    logic                 imem_read;
    logic                 dmem_read;
    logic                 dmem_write;
    logic                 reg_write;
    logic                 mem_to_reg;

    legv8_opdecode u_opdecode (
        .opcode_i  (bus.opcode),
        .cls_o     (cls),
        .illegal_o (dec_illegal)
    );

`ifndef LEGV8_ILLEGAL_TRAP_EN
    // Without trapping, the illegal class is handled through cls alone
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;
`endif

    // State, retired-instruction counter and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; retire marks the last cycle of an instruction
    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        illegal_d = illegal_q;
        retire    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (bus.imem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExec;
`ifdef LEGV8_ILLEGAL_TRAP_EN
                if (dec_illegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
`endif
            end
            StExec: begin
                case (cls)
                    ClsLdur, ClsStur: state_d = StMem;
                    ClsRtype:         state_d = StWb;
                    // Branches retire here; an untrapped illegal opcode passes
                    // through EXEC as a bubble so it costs the same as a branch
                    default:          retire  = 1'b1;
                endcase
            end
            StMem: begin
                if (bus.dmem_ready) begin
                    if (cls == ClsLdur) begin
                        state_d = StWb;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            StWb: begin
                retire = 1'b1;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + 1'b1;
            state_d   = bus.run ? StFetch : StIdle;
        end
    end

    // Moore-style datapath controls; only the ready/zero qualified strobes
    // look at inputs
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        imm_sel    = ImmD;
        alu_src    = 1'b0;
        alu_op     = AluAdd;
        imem_read  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        unique case (state_q)
            StFetch: begin
                imem_read = 1'b1;
                ir_write  = bus.imem_ready;
                pc_write  = bus.imem_ready;
            end
            StDecode: begin
                imm_sel = imm_sel_of(cls);
            end
            StExec: begin
                imm_sel = imm_sel_of(cls);
                case (cls)
                    ClsLdur, ClsStur: begin
                        alu_src = 1'b1;
                        alu_op  = AluAdd;
                    end
                    ClsRtype: begin
                        alu_op = AluFunct;
                    end
                    ClsCbz: begin
                        alu_op   = AluPassB;
                        pc_write = bus.zero;
                        pc_src   = 1'b1;
                    end
                    ClsB: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                imm_sel    = imm_sel_of(cls);
                dmem_read  = (cls == ClsLdur);
                dmem_write = (cls == ClsStur);
            end
            StWb: begin
                imm_sel    = imm_sel_of(cls);
                reg_write  = 1'b1;
                mem_to_reg = (cls == ClsLdur);
            end
            default: ;
        endcase
    end

    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.imm_sel    = imm_sel;
    assign bus.alu_src    = alu_src;
    assign bus.alu_op     = alu_op;
    assign bus.imem_read  = imem_read;
    assign bus.dmem_read  = dmem_read;
    assign bus.dmem_write = dmem_write;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.illegal    = illegal_q;
    assign bus.instret    = instret_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Self-checking bench for legv8_mc_ctrl. Each instruction is expanded into
// the list of cycles it must take and the control vector each cycle must show;
// a compare process checks the DUT against that every cycle. The counter is
// built 8 bits wide so the wrap is reached by the random stream.
`timescale 1ns/1ps
module tb_legv8_mc_ctrl;
    import legv8_pkg::*;

    localparam int unsigned IW = 8;

    // Encodings written out independently of the package
    localparam logic [10:0] TLdur = 11'b11111000010;
    localparam logic [10:0] TStur = 11'b11111000000;
    localparam logic [10:0] TAdd  = 11'b10001011000;
    localparam logic [10:0] TSub  = 11'b11001011000;
    localparam logic [10:0] TAnd  = 11'b10001010000;
    localparam logic [10:0] TOrr  = 11'b10101010000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    legv8_mc_ctrl_if #(.INSTRET_W(IW)) bus ();

    legv8_mc_ctrl #(.INSTRET_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       imem_read;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] imm_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       dmem_read;
        logic       dmem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       busy;
    } outv_t;

    int n_checks = 0;
    int n_pass   = 0;

    outv_t          exp_o;
    logic [IW-1:0]  exp_instret;
    logic           exp_illegal;
    bit             exp_valid = 1'b0;

    // Model state: retired count, sticky flag, whether the sequencer idles
    logic [IW-1:0]  m_instret;
    logic           m_illegal;
    bit             m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    endtask

    function automatic outv_t act_vec();
        return outv_t'({bus.imem_read, bus.ir_write, bus.pc_write, bus.pc_src, bus.imm_sel,
                        bus.alu_src, bus.alu_op, bus.dmem_read, bus.dmem_write,
                        bus.reg_write, bus.mem_to_reg, bus.busy});
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic instr_class_e cls_of(input logic [10:0] op);
        casez (op)
            11'b11111000010: return ClsLdur;
            11'b11111000000: return ClsStur;
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: return ClsRtype;
            11'b10110100???: return ClsCbz;
            11'b000101?????: return ClsB;
            default:         return ClsIllegal;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input instr_class_e c);
        if (c == ClsCbz) return 2'b01;
        if (c == ClsB) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [10:0] rand_op(input bit allow_illegal);
        logic [10:0] op;
        logic [10:0] rt [4];
        int k;
        rt = '{TAdd, TSub, TAnd, TOrr};
        k = $urandom_range(0, allow_illegal ? 5 : 4);
        case (k)
            0: op = TLdur;
            1: op = TStur;
            2: op = rt[$urandom_range(0, 3)];
            3: op = {8'b10110100, 3'($urandom)};
            4: op = {6'b000101, 5'($urandom)};
            default: begin
                do op = 11'($urandom); while (cls_of(op) != ClsIllegal);
            end
        endcase
        return op;
    endfunction

    // Every cycle the bench has an expectation for, compare the whole vector
    always @(negedge clk) begin
        if (exp_valid) begin
            outv_t a;
            a = act_vec();
            check("outputs", {18'b0, a}, {18'b0, exp_o});
            check("instret", 32'(bus.instret), 32'(exp_instret));
            check("illegal", {31'b0, bus.illegal}, {31'b0, exp_illegal});
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic step(input logic run, input logic [10:0] op, input logic z,
                        input logic ir, input logic dr, input outv_t e);
        bus.run        = run;
        bus.opcode     = op;
        bus.zero       = z;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        exp_o          = e;
        exp_instret    = m_instret;
        exp_illegal    = m_illegal;
        exp_valid      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // n idle cycles with run low, then one with run high
    task automatic go_idle(input int n);
        outv_t e;
        e = '0;
        for (int i = 0; i < n; i++) step(1'b0, 11'($urandom), rb(), rb(), rb(), e);
        step(1'b1, 11'($urandom), rb(), rb(), rb(), e);
        m_idle = 1'b0;
    endtask

    // One instruction from FETCH through retire (or trap)
    task automatic do_instr(input logic [10:0] opc, input int wi, input int wd, input logic z,
                            input logic run_mid, input logic run_after, output int ncyc);
        instr_class_e c;
        outv_t e;
        logic [1:0] imm;
        bit last;
        c = cls_of(opc);
        imm = imm_of(c);
        ncyc = 0;
        for (int i = 0; i < wi; i++) begin
            e = '0; e.busy = 1'b1; e.imem_read = 1'b1;
            step(run_mid, 11'($urandom), rb(), 1'b0, rb(), e); ncyc++;
        end
        e = '0; e.busy = 1'b1; e.imem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(run_mid, 11'($urandom), rb(), 1'b1, rb(), e); ncyc++;
        e = '0; e.busy = 1'b1; e.imm_sel = imm;
`ifdef LEGV8_ILLEGAL_TRAP_EN
        if (c == ClsIllegal) begin
            step(rb(), opc, rb(), rb(), rb(), e); ncyc++;
            m_illegal = 1'b1;
            return;
        end
`endif
        step(run_mid, opc, rb(), rb(), rb(), e); ncyc++;
        e = '0; e.busy = 1'b1; e.imm_sel = imm; last = 1'b0;
        case (c)
            ClsLdur, ClsStur: begin e.alu_src = 1'b1; e.alu_op = 2'b00; end
            ClsRtype: e.alu_op = 2'b10;
            ClsCbz: begin e.alu_op = 2'b01; e.pc_write = z; e.pc_src = 1'b1; last = 1'b1; end
            ClsB: begin e.pc_write = 1'b1; e.pc_src = 1'b1; last = 1'b1; end
            default: last = 1'b1;
        endcase
        step(last ? run_after : run_mid, opc, (c == ClsCbz) ? z : rb(), rb(), rb(), e); ncyc++;
        if (c == ClsLdur || c == ClsStur) begin
            e = '0; e.busy = 1'b1; e.imm_sel = imm;
            e.dmem_read = (c == ClsLdur); e.dmem_write = (c == ClsStur);
            for (int i = 0; i < wd; i++) begin
                step(run_mid, opc, rb(), rb(), 1'b0, e); ncyc++;
            end
            last = (c == ClsStur);
            step(last ? run_after : run_mid, opc, rb(), rb(), 1'b1, e); ncyc++;
        end
        if (c == ClsLdur || c == ClsRtype) begin
            e = '0; e.busy = 1'b1; e.imm_sel = imm; e.reg_write = 1'b1;
            e.mem_to_reg = (c == ClsLdur);
            step(run_after, opc, rb(), rb(), rb(), e); ncyc++;
        end
        m_instret = m_instret + 1'b1;
        m_idle = !run_after;
    endtask

    // STUR held in MEM, then asynchronous reset between clock edges
    task automatic stur_reset();
        outv_t e;
        e = '0; e.busy = 1'b1; e.imem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, 11'h0, 1'b0, 1'b1, 1'b0, e);
        e = '0; e.busy = 1'b1;
        step(1'b1, TStur, 1'b0, 1'b0, 1'b0, e);
        e.alu_src = 1'b1;
        step(1'b1, TStur, 1'b0, 1'b0, 1'b0, e);
        e = '0; e.busy = 1'b1; e.dmem_write = 1'b1;
        step(1'b1, TStur, 1'b0, 1'b0, 1'b0, e);
        exp_valid = 1'b0;
        #1;
        check("stur_write_before_rst", {31'b0, bus.dmem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("stur_write_after_rst", {31'b0, bus.dmem_write}, 32'd0);
        check("busy_after_rst", {31'b0, bus.busy}, 32'd0);
        check("instret_after_rst", 32'(bus.instret), 32'd0);
        m_instret = '0;
        m_illegal = 1'b0;
        m_idle = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit allow_ill;
        outv_t e;
        bus.run = 1'b0; bus.opcode = '0; bus.zero = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        m_instret = '0; m_illegal = 1'b0; m_idle = 1'b1;
`ifdef LEGV8_ILLEGAL_TRAP_EN
        allow_ill = 1'b0;
`else
        allow_ill = 1'b1;
`endif

        #12;
        check("reset_outputs", {18'b0, act_vec()}, 32'd0);
        check("reset_instret", 32'(bus.instret), 32'd0);
        check("reset_illegal", {31'b0, bus.illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD with zero wait states
        go_idle(0);
        do_instr(TAdd, 0, 0, 1'b0, 1'b1, 1'b1, n);
        check("add_cycles", 32'(n), 32'd4);
        check("add_instret", 32'(bus.instret), 32'd1);

        // LDUR with two data wait states
        do_instr(TLdur, 0, 2, 1'b0, 1'b1, 1'b1, n);
        check("ldur_cycles", 32'(n), 32'd7);

        // CBZ taken and not taken
        do_instr({8'b10110100, 3'b101}, 0, 0, 1'b1, 1'b1, 1'b1, n);
        check("cbz_taken_cycles", 32'(n), 32'd3);
        do_instr({8'b10110100, 3'b010}, 0, 0, 1'b0, 1'b1, 1'b1, n);
        check("cbz_nt_cycles", 32'(n), 32'd3);

        // run low throughout an R-type: still completes, then idles
        do_instr(TOrr, 1, 0, 1'b0, 1'b0, 1'b0, n);
        check("orr_cycles", 32'(n), 32'd5);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        check("instret_5", 32'(bus.instret), 32'd5);

        // Reset while a store is waiting on data memory
        go_idle(1);
        stur_reset();
        go_idle(2);

`ifndef LEGV8_ILLEGAL_TRAP_EN
        do_instr(11'h000, 0, 0, 1'b0, 1'b1, 1'b1, n);
        check("nop_cycles", 32'(n), 32'd3);
        check("nop_instret", 32'(bus.instret), 32'd1);
`endif

        // Random stream, long enough for the 8-bit counter to wrap
        for (int i = 0; i < 320; i++) begin
            if (m_idle) go_idle($urandom_range(0, 2));
            do_instr(rand_op(allow_ill), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                     $urandom_range(0, 2), rb(), rb(), $urandom_range(0, 3) != 0, n);
        end

`ifdef LEGV8_ILLEGAL_TRAP_EN
        if (m_idle) go_idle(0);
        do_instr(11'h000, 0, 0, 1'b0, 1'b1, 1'b1, n);
        check("trap_cycles", 32'(n), 32'd2);
        e = '0; e.busy = 1'b1;
        for (int i = 0; i < 10; i++) step(rb(), 11'($urandom), rb(), rb(), rb(), e);
        check("trap_illegal", {31'b0, bus.illegal}, 32'd1);
`else
        e = '0;
`endif
        exp_valid = 1'b0;
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
